// File: rtl/ir_sense_sequencer.sv
// Sequences the shared A2D across the in/mid/out IR pairs: emitter on, settle, convert left then right.
// Optional IR_PWM_EN: the active emitter enable is PWM-gated at IR_DUTY/256 instead of held solid high.
module ir_sense_sequencer #(
  parameter int unsigned SETTLE_CYC  = 4096,
  parameter int unsigned TIMEOUT_CYC = 1024
`ifdef IR_PWM_EN
  , parameter logic [7:0] IR_DUTY    = 8'h8C
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic        IR_in_en,
  output logic        IR_mid_en,
  output logic        IR_out_en,
  output logic [11:0] in_lft,
  output logic [11:0] in_rht,
  output logic [11:0] mid_lft,
  output logic [11:0] mid_rht,
  output logic [11:0] out_lft,
  output logic [11:0] out_rht,
  output logic        vld,
  output logic        err,
  output logic        busy
);

  localparam int unsigned MAX_CYC = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, CONV_L, WAIT_L, CONV_R, WAIT_R} state_t;

  state_t           state, state_nxt;
  logic [1:0]       pair, pair_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             act, act_nxt;
  logic             strt_nxt, vld_nxt, err_nxt;
  logic [2:0]       chnnl_nxt;
  logic             lat_en;
  logic [2:0]       lat_idx;
  logic             pwm_on_c;

  // Channel map: in L0 R1, mid L4 R2, out L3 R7
  function automatic logic [2:0] chan_of(input logic [1:0] p, input logic rgt);
    case ({p, rgt})
      3'b000:  chan_of = 3'd0;
      3'b001:  chan_of = 3'd1;
      3'b010:  chan_of = 3'd4;
      3'b011:  chan_of = 3'd2;
      3'b100:  chan_of = 3'd3;
      3'b101:  chan_of = 3'd7;
      default: chan_of = 3'd0;
    endcase
  endfunction

`ifdef IR_PWM_EN
  logic [7:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (rst) pwm_cnt <= 8'd0;
    else     pwm_cnt <= pwm_cnt + 8'd1;
  end

  assign pwm_on_c = (pwm_cnt < IR_DUTY);
`else
  assign pwm_on_c = 1'b1;
`endif

  // Next-state and next-output logic; act is the un-PWM'd emitter window of the current pair
  always_comb begin
    state_nxt = state;
    pair_nxt  = pair;
    cnt_nxt   = cnt + CNT_W'(1);
    act_nxt   = act;
    strt_nxt  = 1'b0;
    chnnl_nxt = chnnl;
    vld_nxt   = 1'b0;
    err_nxt   = err;
    lat_en    = 1'b0;
    lat_idx   = 3'd0;

    if (state != IDLE && !en) begin
      state_nxt = IDLE;
      act_nxt   = 1'b0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          act_nxt = 1'b0;
          if (en) begin
            state_nxt = SETTLE;
            pair_nxt  = 2'd0;
            act_nxt   = 1'b1;
          end
        end
        SETTLE: begin
          // After a timeout the emitter was dropped for one cycle; only count while it is on
          act_nxt = 1'b1;
          if (!act) begin
            cnt_nxt = cnt;
          end else if (cnt == SETTLE_LAST) begin
            state_nxt = CONV_L;
            cnt_nxt   = '0;
            strt_nxt  = 1'b1;
            chnnl_nxt = chan_of(pair, 1'b0);
          end
        end
        CONV_L: begin
          state_nxt = WAIT_L;
          cnt_nxt   = '0;
        end
        CONV_R: begin
          state_nxt = WAIT_R;
          cnt_nxt   = '0;
        end
        WAIT_L, WAIT_R: begin
          if (cnv_cmplt) begin
            lat_en  = 1'b1;
            lat_idx = {pair, state == WAIT_R};
            cnt_nxt = '0;
            if (state == WAIT_L) begin
              state_nxt = CONV_R;
              strt_nxt  = 1'b1;
              chnnl_nxt = chan_of(pair, 1'b1);
            end else if (pair != 2'd2) begin
              state_nxt = SETTLE;
              pair_nxt  = pair + 2'd1;
            end else begin
              state_nxt = SETTLE;
              pair_nxt  = 2'd0;
              vld_nxt   = 1'b1;
              err_nxt   = 1'b0;
            end
          end else if (cnt == TIMEOUT_LAST) begin
            state_nxt = SETTLE;
            pair_nxt  = 2'd0;
            act_nxt   = 1'b0;
            err_nxt   = 1'b1;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          act_nxt   = 1'b0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pair      <= 2'd0;
      cnt       <= '0;
      act       <= 1'b0;
      strt_cnv  <= 1'b0;
      chnnl     <= 3'd0;
      vld       <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      IR_in_en  <= 1'b0;
      IR_mid_en <= 1'b0;
      IR_out_en <= 1'b0;
    end else begin
      state     <= state_nxt;
      pair      <= pair_nxt;
      cnt       <= cnt_nxt;
      act       <= act_nxt;
      strt_cnv  <= strt_nxt;
      chnnl     <= chnnl_nxt;
      vld       <= vld_nxt;
      err       <= err_nxt;
      busy      <= (state_nxt != IDLE);
      IR_in_en  <= act_nxt && (state_nxt != IDLE) && (pair_nxt == 2'd0) && pwm_on_c;
      IR_mid_en <= act_nxt && (state_nxt != IDLE) && (pair_nxt == 2'd1) && pwm_on_c;
      IR_out_en <= act_nxt && (state_nxt != IDLE) && (pair_nxt == 2'd2) && pwm_on_c;
    end
  end

  // Readings only move on their own completion
  always_ff @(posedge clk) begin
    if (rst) begin
      in_lft  <= 12'h000;
      in_rht  <= 12'h000;
      mid_lft <= 12'h000;
      mid_rht <= 12'h000;
      out_lft <= 12'h000;
      out_rht <= 12'h000;
    end else if (lat_en) begin
      case (lat_idx)
        3'd0:    in_lft  <= res;
        3'd1:    in_rht  <= res;
        3'd2:    mid_lft <= res;
        3'd3:    mid_rht <= res;
        3'd4:    out_lft <= res;
        3'd5:    out_rht <= res;
        default: ;
      endcase
    end
  end

endmodule
